// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path definitions: the nop encoding, PC step and the queued entry layout.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INCR   = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        misaligned;
   } fetch_entry_t;

   function automatic logic pc_is_misaligned(input logic [31:0] pc);
      return (pc[1:0] != 2'b00);
   endfunction

   // Carry out of bit 31 is dropped, so the top word address wraps to zero.
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + PC_INCR;
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle; the queue uses the slave view, its environment the master view.
interface fetch_queue_if #(
   parameter int PTR_W = 2
);
   logic              in_valid;
   logic [31:0]       in_pc;
   logic [31:0]       in_instr;
   logic              in_ready;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_pc;
   logic [31:0]       out_pc_plus4;
   logic [31:0]       out_instr;
   logic              out_misaligned;
   logic [PTR_W:0]    count;

   modport slave (
      input  in_valid, in_pc, in_instr, flush, out_ready,
      output in_ready, out_valid, out_pc, out_pc_plus4, out_instr, out_misaligned, count
   );

   modport master (
      output in_valid, in_pc, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_pc_plus4, out_instr, out_misaligned, count
   );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue between the PC/instruction memory and decode, with single-cycle flush.
module fetch_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic          clk,
   input  logic          rst,
   fetch_queue_if.slave  bus
);

   localparam logic [PTR_W:0]   C_FULL    = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   C_CNT_ONE = 1;
   localparam logic [PTR_W-1:0] C_PTR_ONE = 1;

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W:0]   r_count;

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_push;
   logic             w_pop;
   fetch_entry_t     w_wr_entry;
   fetch_entry_t     w_head;

   // Status depends only on registered count, so in_ready never sees out_ready.
   assign w_in_ready  = (r_count != C_FULL);
   assign w_out_valid = (r_count != '0);

   assign w_push = bus.in_valid & w_in_ready  & ~bus.flush;
   assign w_pop  = w_out_valid  & bus.out_ready & ~bus.flush;

   assign w_wr_entry.pc         = bus.in_pc;
   assign w_wr_entry.instr      = bus.in_instr;
   assign w_wr_entry.misaligned = pc_is_misaligned(bus.in_pc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_wr_entry;
      end
   end

   assign w_head = r_mem[r_rd_ptr];

   always_comb begin
      bus.out_pc         = '0;
      bus.out_pc_plus4   = '0;
      bus.out_instr      = NOP_INSTR;
      bus.out_misaligned = 1'b0;
      if (w_out_valid) begin
         bus.out_pc         = w_head.pc;
         bus.out_pc_plus4   = pc_next(w_head.pc);
         bus.out_instr      = w_head.instr;
         bus.out_misaligned = w_head.misaligned;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.count     = r_count;

endmodule
